// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Feeds per-digit seven-segment decoders and supplies a leading-zero blank mask.
//
// Ports:
//   clk_i    - system clock, rising edge
//   reset_i  - asynchronous active-high reset
//   start_i  - request conversion of bin_i; only honoured while idle
//   bin_i    - unsigned binary value, captured on an accepted start
//   busy_o   - high while a conversion is in progress
//   done_o   - one-cycle pulse when bcd_o/blank_o update
//   bcd_o    - nibble i = decimal digit i (nibble 0 least significant), held between results
//   blank_o  - bit i set when digit i is a leading zero; bit 0 is always clear

module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [DIGITS-1:0]     blank_o
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;

    // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
    function automatic bit digits_fit(input int unsigned d, input int unsigned w);
        longint unsigned p10;
        longint unsigned max_bin;
        p10 = 1;
        for (int unsigned i = 0; i < d; i++) begin
            p10 = p10 * 10;
        end
        max_bin = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return p10 > max_bin;
    endfunction

    if (!digits_fit(DIGITS, BIN_W)) begin : g_param_check
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    // Digit i is blanked when it and every more-significant digit are zero.
    function automatic logic [DIGITS-1:0] blank_of(input logic [BCD_W-1:0] v);
        logic [DIGITS-1:0] res;
        logic              zero_above;
        res        = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (v[4*i +: 4] == 4'd0);
            res[i]     = zero_above;
        end
        return res;
    endfunction

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [DIGITS-1:0] BlankReset = {{(DIGITS-1){1'b1}}, 1'b0};

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   adjusted;
    logic [BCD_W-1:0]   shifted;

    // Add-3 correction before the shift so every nibble stays a valid decimal digit.
    always_comb begin
        adjusted = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adjusted[BCD_W-2:0], shift_q[BIN_W-1]};
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    shift_d   = bin_i;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = StShift;
                end
            end
            StShift: begin
                shift_d   = {shift_q[BIN_W-2:0], 1'b0};
                scratch_d = shifted;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = shifted;
                    blank_d = blank_of(shifted);
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            blank_q   <= BlankReset;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
            done_q    <= done_d;
        end
    end

    assign busy_o  = (state_q == StShift);
    assign done_o  = done_q;
    assign bcd_o   = bcd_q;
    assign blank_o = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (defaults BIN_W=16, DIGITS=5).
// Expected digits come from plain decimal arithmetic, blank from value magnitude.

module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [4:0]  blank;

    int errors = 0;
    int checks = 0;

    bin_to_bcd_seq #(
        .BIN_W  (16),
        .DIGITS (5)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (start),
        .bin_i   (bin),
        .busy_o  (busy),
        .done_o  (done),
        .bcd_o   (bcd),
        .blank_o (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] model_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] model_blank(input int unsigned v);
        logic [4:0]  r;
        int unsigned p;
        r = '0;
        p = 10;
        for (int i = 1; i < 5; i++) begin
            r[i] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; the next edge is the start edge.
    task automatic start_conv(input logic [15:0] v);
        start = 1'b1;
        bin   = v;
        tick();
        start = 1'b0;
    endtask

    // Counts edges until done; also counts busy cycles and bcd changes before done.
    task automatic wait_done(input logic [19:0] held, output int lat, output int busy_n,
                             output int hold_viol);
        lat = 0;
        busy_n = 0;
        hold_viol = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            if (bcd !== held) hold_viol++;
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int unsigned v, input int lat);
        check({tag, ".latency"}, lat, 16);
        check({tag, ".bcd"}, {12'd0, bcd}, {12'd0, model_bcd(v)});
        check({tag, ".blank"}, {27'd0, blank}, {27'd0, model_blank(v)});
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int busy_n;
        int hold_viol;
        int done_seen;
        logic [15:0] v;
        logic [15:0] specials [6];

        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        tick();
        tick();
        check("reset.bcd", {12'd0, bcd}, 32'h0);
        check("reset.blank", {27'd0, blank}, 32'h1e);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        tick();

        // Zero
        start_conv(16'd0);
        wait_done(20'h0, lat, busy_n, hold_viol);
        check_result("zero", 0, lat);

        // Max value, busy and done widths
        tick();
        start_conv(16'hffff);
        wait_done(20'h0, lat, busy_n, hold_viol);
        check_result("max", 65535, lat);
        check("max.bcd_const", {12'd0, bcd}, 32'h65535);
        check("max.busy_cycles", busy_n, 16);
        tick();
        check("max.done_width", {31'd0, done}, 32'd0);

        // Back-to-back: second start in the first done cycle
        start_conv(16'd1234);
        wait_done(20'h65535, lat, busy_n, hold_viol);
        check_result("b2b_first", 1234, lat);
        check("b2b_first.blank_const", {27'd0, blank}, 32'h10);
        start_conv(16'd7);
        check("b2b.done_drop", {31'd0, done}, 32'd0);
        wait_done(20'h01234, lat, busy_n, hold_viol);
        check("b2b.hold", hold_viol, 0);
        check_result("b2b_second", 7, lat);

        // Start during conversion is ignored
        tick();
        start_conv(16'd500);
        repeat (4) tick();
        start = 1'b1;
        bin   = 16'd9999;
        tick();
        start = 1'b0;
        bin   = 16'd1;
        wait_done(20'h00007, lat, busy_n, hold_viol);
        check("ignore.latency", lat, 11);
        check("ignore.bcd", {12'd0, bcd}, 32'h00500);
        check("ignore.blank", {27'd0, blank}, 32'h18);
        tick();

        // Reset mid-conversion
        start_conv(16'd4321);
        repeat (7) tick();
        reset = 1'b1;
        #1;
        check("abort.bcd", {12'd0, bcd}, 32'h0);
        check("abort.blank", {27'd0, blank}, 32'h1e);
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.done", {31'd0, done}, 32'd0);
        tick();
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) done_seen++;
            tick();
        end
        check("abort.no_done", done_seen, 0);
        start_conv(16'd10);
        wait_done(20'h0, lat, busy_n, hold_viol);
        check_result("after_abort", 10, lat);
        check("after_abort.blank_const", {27'd0, blank}, 32'h1c);

        // Sweep: boundary values first, then random, issued back-to-back
        specials[0] = 16'd9;
        specials[1] = 16'd10;
        specials[2] = 16'd99;
        specials[3] = 16'd100;
        specials[4] = 16'd9999;
        specials[5] = 16'd10000;
        for (int n = 0; n < 1000; n++) begin
            logic [19:0] prev;
            prev = bcd;
            v = (n < 6) ? specials[n] : 16'($urandom_range(0, 65535));
            start_conv(v);
            wait_done(prev, lat, busy_n, hold_viol);
            check("sweep.latency", lat, 16);
            check("sweep.bcd", {12'd0, bcd}, {12'd0, model_bcd(int'(v))});
            check("sweep.blank", {27'd0, blank}, {27'd0, model_blank(int'(v))});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the per-digit seven-segment decoders: each 4-bit BCD nibble drives one decoder's num input. It also produces a leading-zero blank mask, so the display stage can suppress leading zeros instead of showing them.

Parameters:
BIN_W, 16, width of the unsigned binary input.
DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^BIN_W - 1 (elaboration-time assertion).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request conversion of bin; sampled only when busy=0.
bin  input  BIN_W  unsigned binary value, captured on an accepted start.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse when bcd/blank update.
bcd  output  4*DIGITS  result; nibble i = decimal digit i (i=0 is least significant); held until the next done.
blank  output  DIGITS  bit i=1 means digit i is a leading zero and should be blanked.

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, bcd=0, blank={DIGITS-1{1}},0 (value 0 shown as a single "0"). Internal shift/scratch registers and bit counter are cleared.
- Reset asserted mid-conversion aborts it. No done pulse is produced, and outputs take their reset values.
- FSM states: IDLE, SHIFT.
- IDLE: busy=0. On a clk edge with start=1:
  - capture bin into the shift register;
  - clear the BCD scratch register;
  - set bit counter = BIN_W;
  - go to SHIFT.
- SHIFT: busy=1. Each clk edge:
  - (a) every scratch nibble >= 5 gets +3 (4-bit add, no carry out of the nibble);
  - (b) {scratch, shift} shifts left by 1, so the shift register MSB enters scratch bit 0;
  - (c) counter decrements.
- Final SHIFT edge (counter==1):
  - load bcd with the post-shift scratch value;
  - load blank from that value;
  - done<=1;
  - state<=IDLE.
- done deasserts on the following edge unless a new conversion completes on that edge.
- Latency: start sampled at edge E0 gives busy=1 after E0, and bcd/blank/done valid after edge E_BIN_W (BIN_W clocks). With the defaults, done is high 16 clocks after the start edge.
- start while busy=1 is ignored. No queuing; bin changes during conversion have no effect.
- The done cycle is an IDLE cycle (busy=0), so start in that same cycle is accepted: back-to-back conversions run every BIN_W+1 clocks. bcd/blank keep the previous result until the new done.
- blank rule: bit i=1 iff nibble i and all more-significant nibbles are 0, for i>=1. blank[0] is always 0.
- bcd/blank never show intermediate values; they change only on a done edge or on reset.
- Nibbles never exceed 9 for valid parameters. No overflow output is needed, given the elaboration assertion.

Test Plan:
- Reset, then start with bin=0 -> after 16 clocks: done pulse; bcd=0x00000, blank=5'b11110, busy low.
- bin=65535 -> bcd=0x65535, blank=5'b00000. Check busy is high for exactly 16 cycles and done is high for exactly 1 cycle.
- bin=1234 then bin=7 (back-to-back, second start asserted in the first done cycle):
  - first result bcd=0x01234, blank=5'b10000;
  - second result bcd=0x00007, blank=5'b11110, 17 clocks after the first done;
  - bcd holds 0x01234 in between.
- Start bin=500; at clock 5 pulse start with bin=9999 and change bin -> ignored; result bcd=0x00500, blank=5'b11000.
- Start bin=4321; assert reset at clock 8 of the conversion -> outputs return immediately to reset values, no done pulse. A later start with bin=10 gives bcd=0x00010, blank=5'b11100.
- Random sweep of 1000 values (including 9, 10, 99, 100, 9999, 10000) against a reference model: bcd and blank match, and latency is always 16.
